// File: rtl/multi_norm_float_to_fixed_pkg.sv
// Shared float field constants and FSM state type for the
// multi-channel float-to-fixed normaliser.
package multi_norm_float_to_fixed_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;
    localparam int MAN_W    = 23;
    localparam int BIAS     = 127;

    localparam logic [7:0] EXP_SPECIAL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multi_norm_float_to_fixed_core.sv
// Combinational single-precision float to signed fixed converter.
// Optional macro NORM_ROUND_EN: round half away from zero instead of truncating.
module norm_f2x_core
    import multi_norm_float_to_fixed_pkg::*;
#(
    parameter int W_FIX = 16,
    parameter int FRAC  = 8
) (
    input  logic [31:0]      flt,
    output logic [W_FIX-1:0] fix,
    output logic             o_f,
    output logic             u_f
);

    // Magnitude datapath wide enough for sig << (W_FIX-1) plus a round bit
    localparam int MW = W_FIX + 25;

    localparam logic [MW-1:0] ONE     = {{(MW-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0] NEG_MAG = ONE << (W_FIX - 1);
    localparam logic [MW-1:0] POS_MAX = NEG_MAG - ONE;

    localparam logic [W_FIX-1:0] SAT_POS = {1'b0, {(W_FIX-1){1'b1}}};
    localparam logic [W_FIX-1:0] SAT_NEG = {1'b1, {(W_FIX-1){1'b0}}};

    logic          sgn;
    logic [7:0]    expo;
    logic [22:0]   man;
    logic [MW-1:0] ext;
    logic [MW-1:0] mag;
    logic          big;
    int            sh;

    assign sgn  = flt[SIGN_BIT];
    assign expo = flt[EXP_MSB:EXP_LSB];
    assign man  = flt[MAN_MSB:0];
    assign ext  = {{(MW-24){1'b0}}, 1'b1, man};

    // Scale the significand by 2^(exp-bias-23+FRAC), then flag and saturate
    always_comb begin
        fix = '0;
        o_f = 1'b0;
        u_f = 1'b0;
        mag = '0;
        big = 1'b0;
        sh  = $signed({24'd0, expo}) - BIAS - MAN_W + FRAC;
        if (expo == EXP_SPECIAL) begin
            o_f = 1'b1;
            fix = (sgn && man == '0) ? SAT_NEG : SAT_POS;
        end else if (expo == 8'd0) begin
            // Denormals are far below one LSB for any legal FRAC
            u_f = (man != '0);
        end else begin
            if (sh >= W_FIX) begin
                big = 1'b1;
            end else if (sh >= 0) begin
                mag = ext << sh;
            end else begin
`ifdef NORM_ROUND_EN
                mag = ((ext << 1) >> (-sh)) + ONE;
                mag = mag >> 1;
`else
                mag = ext >> (-sh);
`endif
            end
            if (big || (sgn ? (mag > NEG_MAG) : (mag > POS_MAX))) begin
                o_f = 1'b1;
                fix = sgn ? SAT_NEG : SAT_POS;
            end else if (mag == '0) begin
                u_f = 1'b1;
            end else begin
                fix = sgn ? (~mag[W_FIX-1:0] + 1'b1) : mag[W_FIX-1:0];
            end
        end
    end

endmodule

// File: rtl/multi_norm_float_to_fixed.sv
// Multi-channel float-to-fixed converter: captures N_CH floats and converts
// one channel per cycle through a shared core (NORM_ROUND_EN selects rounding).
module multi_norm_float_to_fixed
    import multi_norm_float_to_fixed_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int W_FIX = 16,
    parameter int FRAC  = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  Begin_FSM,
    input  logic [N_CH*32-1:0]    F,
    output logic                  ACK,
    output logic                  BUSY,
    output logic [N_CH*W_FIX-1:0] RESULT,
    output logic [N_CH-1:0]       O_F,
    output logic [N_CH-1:0]       U_F
);

    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [N_CH*32-1:0] f_reg;
    logic [31:0]        flt_sel;
    logic [W_FIX-1:0]   fix;
    logic               o_f;
    logic               u_f;

    // Route the channel addressed by the counter into the shared core
    always_comb begin
        flt_sel = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (cnt == CW'(c)) flt_sel = f_reg[32*c +: 32];
        end
    end

    norm_f2x_core #(
        .W_FIX (W_FIX),
        .FRAC  (FRAC)
    ) u_core (
        .flt (flt_sel),
        .fix (fix),
        .o_f (o_f),
        .u_f (u_f)
    );

    // Control FSM with registered handshake and per-channel result writes
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            cnt    <= '0;
            f_reg  <= '0;
            ACK    <= 1'b0;
            BUSY   <= 1'b0;
            RESULT <= '0;
            O_F    <= '0;
            U_F    <= '0;
        end else begin
            ACK <= 1'b0;
            unique case (state)
                IDLE: begin
                    // BUSY still high here means ACK is showing this cycle
                    if (BUSY) begin
                        BUSY <= 1'b0;
                    end else if (Begin_FSM) begin
                        f_reg <= F;
                        cnt   <= '0;
                        O_F   <= '0;
                        U_F   <= '0;
                        BUSY  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    for (int c = 0; c < N_CH; c++) begin
                        if (cnt == CW'(c)) begin
                            RESULT[W_FIX*c +: W_FIX] <= fix;
                            O_F[c] <= o_f;
                            U_F[c] <= u_f;
                        end
                    end
                    if (cnt == CW'(N_CH - 1)) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    ACK   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
